// File: rtl/rggen_wishbone_request_buffer.sv
// Pipelined Wishbone request buffer: queues upstream requests in a small FIFO, replays them
// one at a time downstream and returns registered responses upstream in order.
module rggen_wishbone_request_buffer #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int DEPTH         = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_s_cyc,
    input  logic                     i_s_stb,
    input  logic [ADDRESS_WIDTH-1:0] i_s_adr,
    input  logic                     i_s_we,
    input  logic [BUS_WIDTH-1:0]     i_s_dat_w,
    input  logic [BUS_WIDTH/8-1:0]   i_s_sel,
    output logic                     o_s_stall,
    output logic                     o_s_ack,
    output logic                     o_s_err,
    output logic                     o_s_rty,
    output logic [BUS_WIDTH-1:0]     o_s_dat_r,
    output logic                     o_m_cyc,
    output logic                     o_m_stb,
    output logic [ADDRESS_WIDTH-1:0] o_m_adr,
    output logic                     o_m_we,
    output logic [BUS_WIDTH-1:0]     o_m_dat_w,
    output logic [BUS_WIDTH/8-1:0]   o_m_sel,
    input  logic                     i_m_stall,
    input  logic                     i_m_ack,
    input  logic                     i_m_err,
    input  logic                     i_m_rty,
    input  logic [BUS_WIDTH-1:0]     i_m_dat_r
);
    localparam int SEL_WIDTH   = BUS_WIDTH / 8;
    localparam int ENTRY_WIDTH = ADDRESS_WIDTH + 1 + BUS_WIDTH + SEL_WIDTH;
    localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_WIDTH   = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [ENTRY_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]   r_wptr;
    logic [PTR_WIDTH-1:0]   r_rptr;
    logic [PTR_WIDTH-1:0]   w_wptr_next;
    logic [PTR_WIDTH-1:0]   w_rptr_next;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [CNT_WIDTH-1:0]   w_count_next;
    logic                   r_abort;
    logic                   w_abort_next;
    logic                   r_ack;
    logic                   r_err;
    logic                   r_rty;
    logic [BUS_WIDTH-1:0]   r_dat_r;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_resp;
    logic                   w_busy;
    logic                   w_flush;
    logic                   w_keep_head;
    logic                   w_forward;
    logic [ENTRY_WIDTH-1:0] w_head;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_WIDTH'(1);
    endfunction

    assign o_s_stall   = (r_count == FULL_CNT) || r_abort;
    assign w_push      = i_s_cyc && i_s_stb && !o_s_stall;
    assign w_busy      = (r_state != StIdle);
    assign w_resp      = i_m_ack || i_m_err || i_m_rty;
    assign w_pop       = ((r_state == StWait) || ((r_state == StReq) && !i_m_stall)) && w_resp;
    assign w_flush     = !i_s_cyc && ((r_count != '0) || w_busy);
    assign w_keep_head = w_busy && !w_pop;
    // A response that completes after (or while) the master abandons its cycle is dropped.
    assign w_forward   = w_pop && !r_abort && i_s_cyc;
    assign w_head      = r_mem[r_rptr];

    always_comb begin
        w_rptr_next  = w_pop ? ptr_inc(r_rptr) : r_rptr;
        w_wptr_next  = w_push ? ptr_inc(r_wptr) : r_wptr;
        w_count_next = r_count;
        if (w_flush) begin
            // Only an in-flight head survives an abort; everything behind it is discarded.
            w_count_next = w_keep_head ? CNT_WIDTH'(1) : '0;
            w_wptr_next  = w_keep_head ? ptr_inc(r_rptr) : w_rptr_next;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_WIDTH'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_abort_next = r_abort;
        if (!w_busy || w_pop) begin
            w_abort_next = 1'b0;
        end else if (!i_s_cyc) begin
            w_abort_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_s_adr, i_s_we, i_s_dat_w, i_s_sel};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_abort <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_dat_r <= '0;
        end else begin
            r_wptr  <= w_wptr_next;
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
            r_abort <= w_abort_next;
            r_err   <= w_forward && i_m_err;
            r_rty   <= w_forward && i_m_rty && !i_m_err;
            r_ack   <= w_forward && i_m_ack && !i_m_err && !i_m_rty;
            if (w_pop) begin
                r_dat_r <= i_m_dat_r;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                // Issue as soon as the entry lands, so a request may go out the cycle after accept.
                if (w_push || ((r_count != '0) && i_s_cyc)) begin
                    w_state_next = StReq;
                end
            end
            StReq: begin
                if (!i_m_stall) begin
                    w_state_next = w_resp ? StIdle : StWait;
                end
            end
            StWait: begin
                if (w_resp) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_m_cyc   = w_busy;
        o_m_stb   = (r_state == StReq);
        o_m_adr   = '0;
        o_m_we    = 1'b0;
        o_m_dat_w = '0;
        o_m_sel   = '0;
        if (w_busy) begin
            {o_m_adr, o_m_we, o_m_dat_w, o_m_sel} = w_head;
        end
        o_s_ack   = r_ack;
        o_s_err   = r_err;
        o_s_rty   = r_rty;
        o_s_dat_r = r_dat_r;
    end
endmodule

// File: tb/tb_rggen_wishbone_request_buffer.sv
// Bench for rggen_wishbone_request_buffer: directed scenarios plus random traffic, with a
// downstream slave model and an upstream response scoreboard.
module tb_rggen_wishbone_request_buffer;
    localparam int AW    = 8;
    localparam int BW    = 32;
    localparam int SW    = BW / 8;
    localparam int DEPTH = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_s_cyc, i_s_stb, i_s_we;
    logic [AW-1:0] i_s_adr;
    logic [BW-1:0] i_s_dat_w;
    logic [SW-1:0] i_s_sel;
    logic          o_s_stall, o_s_ack, o_s_err, o_s_rty;
    logic [BW-1:0] o_s_dat_r;
    logic          o_m_cyc, o_m_stb, o_m_we;
    logic [AW-1:0] o_m_adr;
    logic [BW-1:0] o_m_dat_w;
    logic [SW-1:0] o_m_sel;
    logic          i_m_stall, i_m_ack, i_m_err, i_m_rty;
    logic [BW-1:0] i_m_dat_r;

    always #5 clk = ~clk;

    rggen_wishbone_request_buffer #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .DEPTH         (DEPTH)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_s_cyc   (i_s_cyc),
        .i_s_stb   (i_s_stb),
        .i_s_adr   (i_s_adr),
        .i_s_we    (i_s_we),
        .i_s_dat_w (i_s_dat_w),
        .i_s_sel   (i_s_sel),
        .o_s_stall (o_s_stall),
        .o_s_ack   (o_s_ack),
        .o_s_err   (o_s_err),
        .o_s_rty   (o_s_rty),
        .o_s_dat_r (o_s_dat_r),
        .o_m_cyc   (o_m_cyc),
        .o_m_stb   (o_m_stb),
        .o_m_adr   (o_m_adr),
        .o_m_we    (o_m_we),
        .o_m_dat_w (o_m_dat_w),
        .o_m_sel   (o_m_sel),
        .i_m_stall (i_m_stall),
        .i_m_ack   (i_m_ack),
        .i_m_err   (i_m_err),
        .i_m_rty   (i_m_rty),
        .i_m_dat_r (i_m_dat_r)
    );

    typedef struct packed {
        logic [AW-1:0] adr;
        logic          we;
        logic [BW-1:0] dat;
        logic [SW-1:0] sel;
    } req_t;
    typedef struct {
        logic [2:0]    lines;  // {err, rty, ack} the slave will drive
        logic [BW-1:0] dat;
    } plan_t;
    typedef struct {
        logic [2:0]    kind;   // {err, rty, ack} expected upstream
        logic [BW-1:0] dat;
    } resp_t;

    req_t  exp_req[$];
    plan_t plan_q[$];
    resp_t exp_up[$];

    int            n_vec = 0;
    int            n_err = 0;
    int            stall_left = 0;
    int            fixed_delay = 1;
    bit            rand_stall = 0;
    bit            suppress = 0;
    bit            pending = 0;
    int            dly_left = 0;
    plan_t         cur;
    logic [BW-1:0] last_dat = '0;
    bit            hold_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream response rule: err beats rty beats ack.
    function automatic logic [2:0] up_kind(input logic [2:0] lines);
        if (lines[2]) return 3'b100;
        if (lines[1]) return 3'b010;
        return 3'b001;
    endfunction

    task automatic slave_respond();
        {i_m_err, i_m_rty, i_m_ack} = cur.lines;
        i_m_dat_r = cur.dat;
        pending = 0;
        if (suppress) begin
            suppress = 0;
        end else begin
            resp_t r;
            r.kind = up_kind(cur.lines);
            r.dat  = cur.dat;
            exp_up.push_back(r);
        end
    endtask

    // Downstream slave model, also checks every request it accepts.
    initial begin
        {i_m_stall, i_m_ack, i_m_err, i_m_rty} = '0;
        i_m_dat_r = '0;
        forever begin
            @(negedge clk);
            {i_m_stall, i_m_ack, i_m_err, i_m_rty} = '0;
            i_m_dat_r = $urandom;
            if (!rst_n) begin
                pending = 0;
                suppress = 0;
                stall_left = 0;
            end else if (o_m_stb) begin
                if (stall_left > 0) begin
                    i_m_stall = 1'b1;
                    stall_left--;
                end else if (rand_stall && ($urandom_range(0, 3) == 0)) begin
                    i_m_stall = 1'b1;
                end else begin
                    if (exp_req.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_req: got adr 0x%0h expected none", o_m_adr);
                    end else begin
                        req_t e;
                        e = exp_req.pop_front();
                        chk("req_fields", 64'({o_m_adr, o_m_we, o_m_dat_w, o_m_sel}), 64'(e));
                    end
                    if (plan_q.size() != 0) cur = plan_q.pop_front();
                    else begin
                        cur.lines = 3'b001;
                        cur.dat   = '0;
                    end
                    dly_left = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 2);
                    if (dly_left == 0) slave_respond();
                    else pending = 1;
                end
            end else if (pending && o_m_cyc) begin
                dly_left--;
                if (dly_left == 0) slave_respond();
            end
        end
    end

    // Upstream monitor: every response pulse must match the next scoreboard entry.
    initial begin
        logic [2:0] r;
        resp_t      e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                r = {o_s_err, o_s_rty, o_s_ack};
                if (r != 3'b000) begin
                    if (exp_up.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_resp: got %b expected none at %0t", r, $time);
                    end else begin
                        e = exp_up.pop_front();
                        chk("resp_kind", 64'(r), 64'(e.kind));
                        chk("resp_dat", 64'(o_s_dat_r), 64'(e.dat));
                        last_dat   = e.dat;
                        hold_valid = 1;
                    end
                end else if (hold_valid) begin
                    chk("dat_hold", 64'(o_s_dat_r), 64'(last_dat));
                end
            end
        end
    end

    task automatic issue(input logic [AW-1:0] adr, input logic we, input logic [BW-1:0] dat,
                         input logic [SW-1:0] sel, input logic [2:0] lines,
                         input logic [BW-1:0] rdat);
        int    guard = 0;
        req_t  q;
        plan_t p;
        i_s_cyc = 1'b1;
        i_s_stb = 1'b1;
        i_s_adr = adr;
        i_s_we = we;
        i_s_dat_w = dat;
        i_s_sel = sel;
        while (o_s_stall && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (o_s_stall) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: got stall 1 expected 0 at %0t", $time);
            i_s_stb = 1'b0;
            return;
        end
        q = '{adr: adr, we: we, dat: dat, sel: sel};
        p.lines = lines;
        p.dat = rdat;
        exp_req.push_back(q);
        plan_q.push_back(p);
        @(negedge clk);
        i_s_stb = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_up.size() != 0 || plan_q.size() != 0 || pending || o_m_cyc) && guard < 500)
        begin
            @(negedge clk);
            guard++;
        end
        chk("drain_left", 64'(exp_up.size() + plan_q.size() + exp_req.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int guard;
        {i_s_cyc, i_s_stb, i_s_we} = '0;
        i_s_adr = '0;
        i_s_dat_w = '0;
        i_s_sel = '0;
        repeat (3) @(negedge clk);
        chk("rst_m", 64'({o_m_cyc, o_m_stb, o_m_adr, o_m_we, o_m_dat_w, o_m_sel}), 64'd0);
        chk("rst_s", 64'({o_s_stall, o_s_ack, o_s_err, o_s_rty}), 64'd0);
        chk("rst_dat", 64'(o_s_dat_r), 64'd0);
        rst_n = 1'b1;
        last_dat = '0;
        hold_valid = 1;
        @(negedge clk);

        // Single write: stb the cycle after accept, ack upstream three cycles after accept.
        fixed_delay = 1;
        issue(8'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, 32'h0000_5A5A);
        chk("t1_stb", 64'(o_m_stb), 64'd1);
        chk("t1_fields", 64'({o_m_adr, o_m_we, o_m_dat_w, o_m_sel}),
            64'({8'h10, 1'b1, 32'hDEADBEEF, 4'hF}));
        @(negedge clk);
        chk("t1_wait", 64'({o_m_cyc, o_m_stb}), 64'b10);
        @(negedge clk);
        chk("t1_ack", 64'(o_s_ack), 64'd1);
        @(negedge clk);
        chk("t1_empty", 64'({o_m_cyc, o_s_stall}), 64'd0);

        // Back-to-back reads against a stalled slave fill the FIFO.
        fixed_delay = -1;
        stall_left = 3;
        for (int k = 1; k <= 4; k++) begin
            issue(AW'(8'h20 + k), 1'b0, '0, 4'hF, 3'b001, BW'(k));
            if (k == DEPTH) chk("t2_full_stall", 64'(o_s_stall), 64'd1);
        end
        drain();

        // Error on the middle transaction.
        fixed_delay = 1;
        issue(8'h30, 1'b0, '0, 4'hF, 3'b001, 32'hA1);
        issue(8'h31, 1'b0, '0, 4'hF, 3'b100, 32'hA2);
        issue(8'h32, 1'b0, '0, 4'hF, 3'b001, 32'hA3);
        drain();

        // Abort with two queued behind one outstanding transaction.
        fixed_delay = 5;
        issue(8'h40, 1'b0, '0, 4'hF, 3'b001, 32'hB0);
        issue(8'h41, 1'b0, '0, 4'hF, 3'b001, 32'hB1);
        issue(8'h42, 1'b0, '0, 4'hF, 3'b001, 32'hB2);
        chk("t4_in_wait", 64'({o_m_cyc, o_m_stb}), 64'b10);
        i_s_cyc = 1'b0;
        exp_req.delete();
        plan_q.delete();
        suppress = 1;
        hold_valid = 0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (o_m_cyc) chk("t4_abort_stall", 64'(o_s_stall), 64'd1);
        end while (o_m_cyc && guard < 20);
        chk("t4_idle", 64'({o_m_cyc, o_s_stall}), 64'd0);
        repeat (3) @(negedge clk);
        i_s_cyc = 1'b1;
        @(negedge clk);
        chk("t4_reopen", 64'(o_s_stall), 64'd0);

        // Reset while a transaction is outstanding.
        fixed_delay = 8;
        issue(8'h50, 1'b1, 32'h1234_5678, 4'h3, 3'b001, 32'hC0);
        @(negedge clk);
        chk("t5_in_wait", 64'({o_m_cyc, o_m_stb}), 64'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_m", 64'({o_m_cyc, o_m_stb, o_m_adr, o_m_we, o_m_dat_w, o_m_sel}), 64'd0);
        chk("t5_rst_s", 64'({o_s_stall, o_s_ack, o_s_err, o_s_rty}), 64'd0);
        chk("t5_rst_dat", 64'(o_s_dat_r), 64'd0);
        i_s_cyc = 1'b0;
        exp_req.delete();
        plan_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_dat = '0;
        hold_valid = 1;
        i_s_cyc = 1'b1;
        repeat (12) @(negedge clk);
        chk("t5_quiet", 64'(o_m_cyc), 64'd0);

        // Continuous traffic through the FIFO, exercising pointer wrap.
        fixed_delay = 0;
        rand_stall = 0;
        for (int i = 0; i < 20; i++) begin
            issue(AW'(i), 1'($urandom), $urandom, SW'($urandom), 3'b001, $urandom);
        end
        drain();

        // Random traffic: stalls, latencies and response mixes.
        fixed_delay = -1;
        rand_stall = 1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(AW'($urandom), 1'($urandom), $urandom, SW'($urandom),
                  3'($urandom_range(1, 7)), $urandom);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rggen_wishbone_request_buffer.md
Name: rggen_wishbone_request_buffer

Overview:
Pipelined Wishbone request buffer placed directly upstream of the register-block Wishbone slave adapter. It absorbs back-to-back pipelined requests from the bus master into a small FIFO and replays them one at a time to the downstream slave. Downstream ack/err/rty responses are returned upstream in order, registered. This decouples master issue rate from register-block stall behaviour.

Parameters:
ADDRESS_WIDTH, 8, width of adr on both sides
BUS_WIDTH, 32, width of dat_w/dat_r; sel width is BUS_WIDTH/8
DEPTH, 2, request FIFO entries; legal range 1..16, need not be a power of 2

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_s_cyc  input  1  upstream cycle
i_s_stb  input  1  upstream strobe
i_s_adr  input  ADDRESS_WIDTH  upstream address
i_s_we  input  1  upstream write enable
i_s_dat_w  input  BUS_WIDTH  upstream write data
i_s_sel  input  BUS_WIDTH/8  upstream byte select
o_s_stall  output  1  upstream stall
o_s_ack  output  1  upstream ack
o_s_err  output  1  upstream err
o_s_rty  output  1  upstream rty
o_s_dat_r  output  BUS_WIDTH  upstream read data
o_m_cyc  output  1  downstream cycle
o_m_stb  output  1  downstream strobe
o_m_adr  output  ADDRESS_WIDTH  downstream address
o_m_we  output  1  downstream write enable
o_m_dat_w  output  BUS_WIDTH  downstream write data
o_m_sel  output  BUS_WIDTH/8  downstream byte select
i_m_stall  input  1  downstream stall
i_m_ack  input  1  downstream ack
i_m_err  input  1  downstream err
i_m_rty  input  1  downstream rty
i_m_dat_r  input  BUS_WIDTH  downstream read data

Behaviour:
- Clock i_clk; reset i_rst_n, asynchronous, active-low. Reset: all outputs 0, FIFO empty, pointers/count 0, FSM IDLE.
- Accept: push when i_s_cyc && i_s_stb && !o_s_stall; entry = {adr, we, dat_w, sel}.
- o_s_stall = (count == DEPTH) from registered count; no same-cycle pop pass-through.
- Pointers wrap DEPTH-1 -> 0; count width clog2(DEPTH+1); push+pop same cycle leaves count unchanged.
- Downstream FSM, one outstanding transaction:
  IDLE: FIFO non-empty -> REQ next cycle (earliest o_m_stb is accept cycle + 1).
  REQ: o_m_cyc=1, o_m_stb=1, o_m_* driven from FIFO head; !i_m_stall -> WAIT.
  WAIT: o_m_cyc=1, o_m_stb=0; any of i_m_ack/err/rty -> pop head, capture response, -> IDLE.
  Response in REQ cycle with !i_m_stall treated as if in WAIT.
- o_m_adr/we/dat_w/sel hold FIFO head whenever not IDLE, else 0.
- Upstream response: registered one-cycle pulse the cycle after the downstream response; priority err > rty > ack (exactly one asserted). o_s_dat_r = i_m_dat_r captured on any response, held until next response.
- Upstream abort (i_s_cyc low while FIFO non-empty or transaction in flight): non-head entries flushed immediately; in-flight downstream transaction (REQ/WAIT) runs to completion with o_m_cyc held, its response suppressed upstream; entry in REQ is not withdrawn. Pushes during abort completion are blocked (o_s_stall=1) until IDLE.
- Response count equals accepted-request count for every uninterrupted cycle; order preserved.
- Reset mid-operation: immediate return to reset state; no response issued.

Test Plan:
- Single write adr=0x10, dat=0xDEADBEEF, sel=0xF, downstream no stall, ack 1 cycle after stb -> o_m_stb at T+1, o_s_ack pulse at T+3, FIFO empty after.
- DEPTH=2, four back-to-back reads, downstream i_m_stall high 3 cycles -> o_s_stall asserted after 2nd accept, all 4 requests issued in order, 4 acks with dat_r 0x1,0x2,0x3,0x4.
- Downstream err on 2nd of 3 requests -> upstream sequence ack, err, ack; o_s_err one cycle wide; o_s_dat_r updated each response.
- i_s_cyc dropped with 2 queued, 1 in WAIT -> queued entries never reach o_m_stb, in-flight ack not forwarded, o_s_stall=1 until IDLE.
- DEPTH=3 with continuous pushes/pops for 20 transactions -> pointer wrap correct, addresses 0..19 appear downstream in order.
- i_rst_n asserted while in WAIT -> all outputs 0 immediately, no o_s_ack after release.
